// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
// Also provides the worst-case step bound used to size timeouts.
package gcd_pkg;

   localparam int GCD_WIDTH_DEFAULT = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } gcd_state_e;

   // Subtractive mode can take 2^width-1 steps; Stein's mode is linear in width.
   function automatic longint gcd_max_steps(input int width, input bit binary_en);
      if (binary_en) begin
         return longint'(4 * width);
      end
      return (longint'(1) << width) - longint'(1);
   endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: next operands plus termination flag and result.
// GCD_ENGINE_BINARY_EN selects Stein's algorithm with a common-factor-of-two count k.
module gcd_step
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEFAULT,
   parameter int KW    = $clog2(WIDTH) + 1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
`ifdef GCD_ENGINE_BINARY_EN
   input  logic [KW-1:0]    k_i,
   output logic [KW-1:0]    k_o,
`endif
   output logic [WIDTH-1:0] a_o,
   output logic [WIDTH-1:0] b_o,
   output logic [WIDTH-1:0] res_o,
   output logic             term_o
);

   assign term_o = (a_i == '0) || (b_i == '0);

`ifdef GCD_ENGINE_BINARY_EN
   assign res_o = (a_i | b_i) << k_i;

   always_comb begin
      a_o = a_i;
      b_o = b_i;
      k_o = k_i;
      if (!a_i[0] && !b_i[0]) begin
         a_o = a_i >> 1;
         b_o = b_i >> 1;
         k_o = k_i + KW'(1);
      end else if (!a_i[0]) begin
         a_o = a_i >> 1;
      end else if (!b_i[0]) begin
         b_o = b_i >> 1;
      end else if (a_i >= b_i) begin
         a_o = a_i - b_i;
      end else begin
         b_o = b_i - a_i;
      end
   end
`else
   assign res_o = a_i | b_i;

   always_comb begin
      a_o = a_i;
      b_o = b_i;
      if (a_i >= b_i) begin
         a_o = a_i - b_i;
      end else begin
         b_o = b_i - a_i;
      end
   end
`endif

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with ready/start/done handshake, zero flag and step count.
// Define GCD_ENGINE_BINARY_EN to build the Stein's-algorithm datapath.
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] gcd,
   output logic             zero_in,
   output logic [WIDTH-1:0] iters,
   output gcd_state_e       state_dbg
);

   // Handshake: a request is taken on any rising edge where start=1 and ready=1;
   // done pulses for exactly one cycle, and gcd/zero_in/iters hold until the next accept.

   localparam int KW = $clog2(WIDTH) + 1;

   gcd_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d, iters_q, iters_d;
   logic             zero_q, zero_d, done_q, done_d;
   logic [WIDTH-1:0] a_nxt, b_nxt, res;
   logic             term;

`ifdef GCD_ENGINE_BINARY_EN
   logic [KW-1:0]    k_q, k_d, k_nxt;
`endif

   gcd_step #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_step (
      .a_i    (a_q),
      .b_i    (b_q),
`ifdef GCD_ENGINE_BINARY_EN
      .k_i    (k_q),
      .k_o    (k_nxt),
`endif
      .a_o    (a_nxt),
      .b_o    (b_nxt),
      .res_o  (res),
      .term_o (term)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      iters_d = iters_q;
      zero_d  = zero_q;
      done_d  = 1'b0;
`ifdef GCD_ENGINE_BINARY_EN
      k_d     = k_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               gcd_d   = '0;
               iters_d = '0;
               zero_d  = 1'b0;
`ifdef GCD_ENGINE_BINARY_EN
               k_d     = '0;
`endif
               state_d = CALC;
            end
         end
         CALC: begin
            // Termination is tested before stepping so a zero operand costs no step.
            if (term) begin
               gcd_d   = res;
               zero_d  = (a_q == '0) && (b_q == '0);
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               a_d     = a_nxt;
               b_d     = b_nxt;
               iters_d = iters_q + WIDTH'(1);
`ifdef GCD_ENGINE_BINARY_EN
               k_d     = k_nxt;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         iters_q <= '0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef GCD_ENGINE_BINARY_EN
         k_q     <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
         iters_q <= iters_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
`ifdef GCD_ENGINE_BINARY_EN
         k_q     <= k_d;
`endif
      end
   end

   assign ready     = (state_q == IDLE);
   assign done      = done_q;
   assign gcd       = gcd_q;
   assign zero_in   = zero_q;
   assign iters     = iters_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine at WIDTH=16 and WIDTH=8 against a Euclid-based reference.
module tb_gcd_engine;
  import gcd_pkg::*;

`ifdef GCD_ENGINE_BINARY_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16, dn16, z16;
  logic [15:0] g16, it16;
  gcd_state_e  st16;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, dn8, z8;
  logic [7:0]  g8, it8;
  gcd_state_e  st8;

  int n_checks = 0;
  int n_fail   = 0;

  gcd_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .a(a16), .b(b16),
    .ready(rdy16), .done(dn16), .gcd(g16), .zero_in(z16), .iters(it16), .state_dbg(st16)
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
    .ready(rdy8), .done(dn8), .gcd(g8), .zero_in(z8), .iters(it8), .state_dbg(st8)
  );

  // reference model
  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // repeated subtraction count = sum of Euclid quotients
  function automatic int ref_sub_iters(input int x, input int y);
    int n, t;
    n = 0;
    if (x == 0 || y == 0) return 0;
    while (y != 0) begin
      n = n + x / y;
      t = x % y;
      x = y;
      y = t;
    end
    return n;
  endfunction

  // driver tasks
  task automatic issue16(input logic [15:0] av, input logic [15:0] bv);
    s16 = 1'b1; a16 = av; b16 = bv;
    @(negedge clk);
    s16 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
    s8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic wait_done16(input int bound, output int lat, output bit seen, output bit rdy_low);
    lat = 0; seen = 1'b0; rdy_low = 1'b1;
    while (lat <= bound) begin
      if (dn16) begin
        seen = 1'b1;
        break;
      end
      if (rdy16) rdy_low = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done8(input int bound, output int lat, output bit seen);
    lat = 0; seen = 1'b0;
    while (lat <= bound) begin
      if (dn8) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy16); end
    n_checks++; if (dn16 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", dn16); end
    n_checks++; if (g16 !== 16'd0) begin n_fail++; $display("FAIL reset_gcd: got %0d want 0", g16); end
    n_checks++; if (it16 !== 16'd0) begin n_fail++; $display("FAIL reset_iters: got %0d want 0", it16); end
    n_checks++; if (z16 !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", z16); end
    n_checks++; if (st16 !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", st16); end
    n_checks++; if (rdy8 !== 1'b1 || g8 !== 8'd0) begin n_fail++; $display("FAIL reset_dut8: ready %b gcd %0d want 1/0", rdy8, g8); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; bit seen, rl; int exp_it;
    exp_it = BIN ? 7 : ref_sub_iters(48, 18);
    issue16(16'd48, 16'd18);
    wait_done16(200, lat, seen, rl);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL basic_done: no done within 200 cycles"); end
    n_checks++; if (g16 !== 16'(ref_gcd(48, 18))) begin n_fail++; $display("FAIL basic_gcd: got %0d want %0d", g16, ref_gcd(48, 18)); end
    n_checks++; if (it16 !== 16'(exp_it)) begin n_fail++; $display("FAIL basic_iters: got %0d want %0d", it16, exp_it); end
    n_checks++; if (z16 !== 1'b0) begin n_fail++; $display("FAIL basic_zero: got %b want 0", z16); end
    n_checks++; if (lat != exp_it + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_it + 1); end
    n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_in_done: got %b want 1", rdy16); end
    @(negedge clk);
    n_checks++; if (dn16 !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: done still %b want 0", dn16); end
  endtask

  task automatic test_zero();
    int lat; bit seen, rl;
    issue16(16'd0, 16'd35);
    wait_done16(10, lat, seen, rl);
    n_checks++; if (!seen || lat != 1) begin n_fail++; $display("FAIL zero_latency: seen %b lat %0d want 1", seen, lat); end
    n_checks++; if (g16 !== 16'd35) begin n_fail++; $display("FAIL zero_gcd: got %0d want 35", g16); end
    n_checks++; if (it16 !== 16'd0) begin n_fail++; $display("FAIL zero_iters: got %0d want 0", it16); end
    n_checks++; if (z16 !== 1'b0) begin n_fail++; $display("FAIL zero_flag_one: got %b want 0", z16); end
    @(negedge clk);
    issue16(16'd0, 16'd0);
    wait_done16(10, lat, seen, rl);
    n_checks++; if (!seen || lat != 1) begin n_fail++; $display("FAIL zero2_latency: seen %b lat %0d want 1", seen, lat); end
    n_checks++; if (g16 !== 16'd0) begin n_fail++; $display("FAIL zero2_gcd: got %0d want 0", g16); end
    n_checks++; if (z16 !== 1'b1) begin n_fail++; $display("FAIL zero2_flag: got %b want 1", z16); end
    @(negedge clk);
  endtask

  task automatic test_mid_start();
    int lat; bit seen, rl; int exp_it;
    exp_it = BIN ? 7 : ref_sub_iters(48, 18);
    issue16(16'd48, 16'd18);
    @(negedge clk);
    s16 = 1'b1; a16 = 16'd7; b16 = 16'd7;
    @(negedge clk);
    s16 = 1'b0;
    wait_done16(200, lat, seen, rl);
    n_checks++; if (!seen || lat + 2 != exp_it + 1) begin n_fail++; $display("FAIL mid_latency: seen %b lat %0d want %0d", seen, lat + 2, exp_it + 1); end
    n_checks++; if (g16 !== 16'd6) begin n_fail++; $display("FAIL mid_gcd: got %0d want 6", g16); end
    n_checks++; if (it16 !== 16'(exp_it)) begin n_fail++; $display("FAIL mid_iters: got %0d want %0d", it16, exp_it); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit seen, rl; int exp_it; bit held;
    exp_it = BIN ? 6 : ref_sub_iters(12, 8);
    issue16(16'd48, 16'd18);
    wait_done16(200, lat, seen, rl);
    n_checks++; if (!seen || rdy16 !== 1'b1) begin n_fail++; $display("FAIL b2b_first: seen %b ready %b want 1/1", seen, rdy16); end
    s16 = 1'b1; a16 = 16'd12; b16 = 16'd8;
    @(negedge clk);
    s16 = 1'b0;
    n_checks++; if (dn16 !== 1'b0 || g16 !== 16'd0) begin n_fail++; $display("FAIL b2b_accept: done %b gcd %0d want 0/0", dn16, g16); end
    wait_done16(200, lat, seen, rl);
    n_checks++; if (!seen || lat != exp_it + 1) begin n_fail++; $display("FAIL b2b_latency: seen %b lat %0d want %0d", seen, lat, exp_it + 1); end
    n_checks++; if (g16 !== 16'(ref_gcd(12, 8))) begin n_fail++; $display("FAIL b2b_gcd: got %0d want %0d", g16, ref_gcd(12, 8)); end
    held = 1'b1;
    a16 = 16'd99; b16 = 16'd77;
    repeat (5) begin
      @(negedge clk);
      if (g16 !== 16'd4 || it16 !== 16'(exp_it) || dn16 !== 1'b0) held = 1'b0;
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL hold: gcd %0d iters %0d done %b want 4/%0d/0", g16, it16, dn16, exp_it); end
  endtask

  task automatic test_reset_mid();
    bit no_done;
    no_done = 1'b1;
    issue16(16'd1000, 16'd3);
    repeat (10) begin
      if (dn16) no_done = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (rdy16 !== 1'b1 || st16 !== IDLE) begin n_fail++; $display("FAIL rstmid_ready: ready %b state %0d want 1/IDLE", rdy16, st16); end
    n_checks++; if (g16 !== 16'd0 || it16 !== 16'd0) begin n_fail++; $display("FAIL rstmid_regs: gcd %0d iters %0d want 0/0", g16, it16); end
    repeat (500) begin
      @(negedge clk);
      if (dn16) no_done = 1'b0;
    end
    n_checks++; if (!no_done) begin n_fail++; $display("FAIL rstmid_no_done: aborted request produced done"); end
  endtask

  task automatic test_worst_case();
    int lat; bit seen, rl; int bound;
    bound = int'(gcd_max_steps(16, BIN)) + 4;
    issue16(16'hFFFF, 16'd1);
    wait_done16(bound, lat, seen, rl);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL worst_done: none within %0d cycles", bound); end
    n_checks++; if (g16 !== 16'd1) begin n_fail++; $display("FAIL worst_gcd: got %0d want 1", g16); end
    n_checks++; if (!rl) begin n_fail++; $display("FAIL worst_ready: ready rose during CALC"); end
    if (BIN) begin
      n_checks++; if (it16 == 16'd0 || it16 > 16'd64) begin n_fail++; $display("FAIL worst_iters_bin: got %0d want 1..64", it16); end
    end else begin
      n_checks++; if (it16 !== 16'hFFFF) begin n_fail++; $display("FAIL worst_iters: got %0d want 65535", it16); end
    end
    @(negedge clk);
  endtask

  // scoreboard for the 8-bit random sweep
  logic [7:0] exp_q[$];
  int         it_q[$];

  task automatic test_sweep8();
    int lat; bit seen; logic [7:0] av, bv, eg; int ei;
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      if (i % 97 == 0) av = 8'd0;
      if (i % 193 == 0) bv = 8'd0;
      exp_q.push_back(8'(ref_gcd(int'(av), int'(bv))));
      it_q.push_back(ref_sub_iters(int'(av), int'(bv)));
      issue8(av, bv);
      wait_done8(300, lat, seen);
      eg = exp_q.pop_front();
      ei = it_q.pop_front();
      n_checks++; if (!seen || g8 !== eg) begin n_fail++; $display("FAIL sweep_gcd a=%0d b=%0d: got %0d seen %b want %0d", av, bv, g8, seen, eg); end
      n_checks++; if (z8 !== (av == 8'd0 && bv == 8'd0)) begin n_fail++; $display("FAIL sweep_zero a=%0d b=%0d: got %b", av, bv, z8); end
      if (BIN) begin
        n_checks++; if (it8 > 8'd32 || (ei == 0 && it8 != 8'd0)) begin n_fail++; $display("FAIL sweep_iters_bin a=%0d b=%0d: got %0d want <=32", av, bv, it8); end
      end else begin
        n_checks++; if (it8 !== 8'(ei) || lat != ei + 1) begin n_fail++; $display("FAIL sweep_iters a=%0d b=%0d: iters %0d lat %0d want %0d/%0d", av, bv, it8, lat, ei, ei + 1); end
      end
      @(negedge clk);
    end
    issue8(8'd255, 8'd255);
    wait_done8(300, lat, seen);
    n_checks++; if (!seen || g8 !== 8'd255 || it8 !== 8'd1) begin n_fail++; $display("FAIL sweep_255: gcd %0d iters %0d want 255/1", g8, it8); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_zero();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    fork
      test_worst_case();
      test_sweep8();
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
- Parametrised iterative GCD unit; successor to the fixed 16-bit GCD block.
- Adds configurable operand width, a ready/start/done handshake with single-cycle done pulse, a zero-operand flag and an iteration count.
- Optional binary (Stein) algorithm mode for bounded latency.
- Sits as a leaf compute engine behind a register/control FSM; one request in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only when ready=1
- a  in  WIDTH  operand A, sampled on accepting edge
- b  in  WIDTH  operand B, sampled on accepting edge
- ready  out  1  high in IDLE (combinational from state)
- done  out  1  one-cycle pulse, result valid
- gcd  out  WIDTH  result, held until next accepted start or reset
- zero_in  out  1  both operands were 0; valid with done, held like gcd
- iters  out  WIDTH  number of datapath steps taken; held like gcd

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, gcd=0, iters=0, zero_in=0, done=0, internal regs=0. Reset mid-CALC aborts with no done pulse.
- States: IDLE, CALC.
- IDLE:
  - On start=1, latch a_r=a, b_r=b; clear iters, gcd and zero_in; go to CALC.
  - On start=0, stay in IDLE.
- CALC, termination check first:
  - If a_r==0 or b_r==0: gcd <= a_r | b_r; zero_in <= (a_r==0 && b_r==0); done <= 1; go to IDLE.
  - Otherwise perform one step: if a_r >= b_r then a_r -= b_r, else b_r -= a_r; iters += 1.
- done is high only in the first IDLE cycle after CALC and is deasserted by default on every other edge.
- Latency: done is visible (steps+1) cycles after the accepting edge.
- Worst case is a=2^WIDTH-1, b=1, giving 2^WIDTH-1 steps. iters never overflows.
- start while in CALC is ignored; the operands are not re-sampled.
- start during the done-pulse cycle is legal (state is IDLE) and is accepted. The done pulse still completes that cycle.
- Arithmetic is unsigned WIDTH-bit. Subtraction cannot underflow because of the compare.

Optional Feature:
- Macro: GCD_ENGINE_BINARY_EN.
- Defined: CALC uses Stein's algorithm.
  - Extra reg k (clog2(WIDTH)+1 bits) counts common factors of two.
  - Each step performs exactly one of the following, in priority order:
    - both even: shift both right by 1 and k += 1;
    - a_r even: a_r >>= 1;
    - b_r even: b_r >>= 1;
    - otherwise: subtract the smaller from the larger.
  - Termination: gcd = (a_r | b_r) << k.
  - Zero-operand handling, zero_in, the handshake and iters semantics are unchanged.
  - Latency is bounded by 4*WIDTH steps.
- Undefined: subtractive algorithm as above. The k register and shifters are absent.

Decomposition:
- Package gcd_pkg:
  - state enum (IDLE, CALC);
  - default width constant GCD_WIDTH_DEFAULT=16;
  - function returning the worst-case step bound per mode, used by benches for timeouts.
- One sub-module, gcd_step:
  - purely combinational one-iteration datapath;
  - inputs a_r, b_r (and k in binary mode);
  - outputs next a_r, b_r, k and a term flag.
- gcd_engine keeps the FSM, registers, iters and handshake.

Test Plan:
- Basic (WIDTH=16): start with a=48, b=18 → gcd=6, iters=5, zero_in=0; done pulse exactly 1 cycle, 6 cycles after the accepting edge.
- Zero operand: a=0, b=35 → gcd=35, iters=0, zero_in=0, done 1 cycle after accept. Then a=0, b=0 → gcd=0, zero_in=1.
- Worst case: a=65535, b=1 → gcd=1, iters=65535; ready stays 0 throughout. Binary mode: same gcd, iters <= 64.
- Handshake:
  - start pulsed mid-CALC with a=7, b=7 has no effect and the first result completes;
  - start with a=12, b=8 asserted in the done cycle is accepted, giving gcd=4 on the next done;
  - gcd and iters hold until the next accept.
- Reset mid-op: accept a=1000, b=3, assert rst for 1 cycle after 10 cycles → next cycle ready=1, gcd=0, iters=0, and no done pulse ever appears for that request.
- Parametrisation: WIDTH=8, random a/b sweep of 1000 pairs vs reference model, both macro settings, plus a=255, b=255 → gcd=255, iters=1.
